// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - SPI mode-0 master shared by two round-robin requesters
module spi_master_arbiter #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] tx0,
    input  logic       req1,
    input  logic [7:0] tx1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_id,
    output logic       ss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);
    localparam int GAP_CYC = SS_GAP * CLK_DIV;
    localparam int CNT_W   = $clog2(GAP_CYC + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] VALID_AT = CNT_W'(CLK_DIV - 2);
    // The IDLE cycle that follows GAP is the last ss-high cycle of the gap.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 2);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_id_q, rx_id_d;
    logic             ss_q, ss_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             last_q, last_d;
    logic             miso_s1_q, miso_s2_q;
    logic             pick;
    logic [7:0]       tx_sel;

    always_comb begin
        pick   = (req0 && req1) ? ~last_q : req1;
        tx_sel = pick ? tx1 : tx0;

        state_d    = state_q;
        div_cnt_d  = div_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_id_d    = rx_id_q;
        ss_d       = ss_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (req0 || req1) begin
                    gnt_d      = pick ? 2'b10 : 2'b01;
                    tx_shift_d = tx_sel[6:0];
                    mosi_d     = tx_sel[7];
                    busy_d     = 1'b1;
                    ss_d       = 1'b0;
                    bit_cnt_d  = 4'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    sck_d      = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], miso_s2_q};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_cnt_q != 4'd8) begin
                            mosi_d     = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        end
                    end else if (bit_cnt_q == 4'd8) begin
                        state_d = HOLD;
                    end else begin
                        sck_d      = 1'b1;
                        rx_shift_d = {rx_shift_q[6:0], miso_s2_q};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (div_cnt_q == VALID_AT) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_id_d    = gnt_q[1];
                end
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    ss_d      = 1'b1;
                    mosi_d    = 1'b0;
                    gnt_d     = 2'b00;
                    last_d    = gnt_q[1];
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (div_cnt_q == GAP_LAST) begin
                    div_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= 4'd0;
            tx_shift_q <= 7'd0;
            rx_shift_q <= 8'd0;
            gnt_q      <= 2'b00;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_id_q    <= 1'b0;
            ss_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            last_q     <= 1'b1;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_id_q    <= rx_id_d;
            ss_q       <= ss_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            last_q     <= last_d;
            miso_s1_q  <= miso;
            miso_s2_q  <= miso_s1_q;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_id    = rx_id_q;
    assign ss       = ss_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed vector bench for spi_master_arbiter
module tb_spi_master_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] tx0 = 8'h00;
    logic [7:0] tx1 = 8'h00;
    logic       miso = 1'b0;
    logic [1:0] gnt;
    logic       busy, rx_valid, rx_id, ss, sck, mosi;
    logic [7:0] rx_data;

    spi_master_arbiter #(.CLK_DIV(4), .SS_GAP(2)) dut (
        .clk(clk), .rst(rst), .req0(req0), .tx0(tx0), .req1(req1), .tx1(tx1),
        .gnt(gnt), .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id),
        .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: first bit ready at ss fall, next bit after each sck fall.
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] s_shift  = 8'h00;
    logic [7:0] s_rx     = 8'h00;
    always @(negedge ss) begin
        s_shift = slave_tx;
        miso    = slave_tx[7];
    end
    always @(posedge sck) if (ss === 1'b0) s_rx = {s_rx[6:0], mosi};
    always @(negedge sck) if (ss === 1'b0) begin
        s_shift = {s_shift[6:0], 1'b0};
        miso    = s_shift[7];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rv_count = 0;
    always @(negedge clk) if (rx_valid === 1'b1) rv_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_rv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_ss_high(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ss) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        int   rises;
        logic prev;
        rises = 0;
        prev  = sck;
        ok    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sck && !prev) rises++;
            prev = sck;
            if (rises == n) begin ok = 1'b1; return; end
        end
    endtask

    typedef struct {
        logic       r0, r1;
        logic [7:0] t0, t1, slave;
        logic [1:0] exp_gnt;
        logic       exp_id;
        logic [7:0] exp_rx, exp_sent;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit   ok;
        int   t, ss_low, rv_t, busy_t, hi, sck_bad, rv_before;
        logic [7:0] rxd;
        logic       rxid;

        // Round-robin pointer after the simultaneous-request sequence favours requester 1.
        vecs[0] = '{1'b1, 1'b1, 8'h0F, 8'h3C, 8'h96, 2'b10, 1'b1, 8'h96, 8'h3C};
        vecs[1] = '{1'b1, 1'b0, 8'h0F, 8'h00, 8'h0F, 2'b01, 1'b0, 8'h0F, 8'h0F};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 8'h5A, 8'h00, 2'b10, 1'b1, 8'h00, 8'h5A};
        vecs[3] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'hFF, 2'b01, 1'b0, 8'hFF, 8'h80};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h81, 2'b10, 1'b1, 8'h81, 8'hFF};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_id", rx_id, 0);
        rst = 1'b0;

        // Single frame timing
        slave_tx = 8'h3C; tx0 = 8'hA5; req0 = 1'b1;
        wait_gnt(10, ok);
        check("a_grant_seen", ok, 1);
        check("a_gnt", gnt, 2'b01);
        rv_before = rv_count;
        ss_low = 0; rv_t = 0; busy_t = 0; rxd = 8'h00; rxid = 1'b1;
        for (t = 1; t <= 100; t++) begin
            if (!ss) ss_low++;
            if (rx_valid && rv_t == 0) begin
                rv_t = t; rxd = rx_data; rxid = rx_id; req0 = 1'b0;
            end
            if (!busy && busy_t == 0) busy_t = t;
            @(negedge clk);
        end
        check("a_rv_cycle", rv_t, 72);
        check("a_ss_low", ss_low, 72);
        check("a_busy_low", busy_t, 80);
        check("a_rx_data", rxd, 8'h3C);
        check("a_rx_id", rxid, 0);
        check("a_slave_got", s_rx, 8'hA5);
        check("a_rv_pulses", rv_count - rv_before, 1);
        check("a_no_regrant", gnt, 0);

        // Simultaneous requests from reset
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        tx0 = 8'h11; tx1 = 8'h22; slave_tx = 8'h5A; req0 = 1'b1; req1 = 1'b1;
        wait_rv(200, ok);
        check("b_rv1_seen", ok, 1);
        check("b_rv1_id", rx_id, 0);
        check("b_rv1_data", rx_data, 8'h5A);
        check("b_rv1_sent", s_rx, 8'h11);
        req0 = 1'b0; slave_tx = 8'hC3;
        wait_rv(200, ok);
        check("b_rv2_seen", ok, 1);
        check("b_rv2_id", rx_id, 1);
        check("b_rv2_data", rx_data, 8'hC3);
        check("b_rv2_sent", s_rx, 8'h22);
        req1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(50, ok);
        check("b_rr_seen", ok, 1);
        check("b_rr_gnt", gnt, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(100, ok);
        check("b_idle", ok, 1);

        for (int v = 0; v < 5; v++) begin
            tx0 = vecs[v].t0; tx1 = vecs[v].t1; slave_tx = vecs[v].slave;
            req0 = vecs[v].r0; req1 = vecs[v].r1;
            wait_gnt(20, ok);
            check($sformatf("v%0d_grant_seen", v), ok, 1);
            check($sformatf("v%0d_gnt", v), gnt, vecs[v].exp_gnt);
            tx0 = tx0 ^ 8'hF0; tx1 = tx1 ^ 8'hF0;
            req0 = 1'b0; req1 = 1'b0;
            wait_rv(100, ok);
            check($sformatf("v%0d_rv_seen", v), ok, 1);
            check($sformatf("v%0d_rx_id", v), rx_id, vecs[v].exp_id);
            check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            check($sformatf("v%0d_sent", v), s_rx, vecs[v].exp_sent);
            wait_idle(20, ok);
            check($sformatf("v%0d_idle", v), ok, 1);
        end

        // Continuous req1: inter-frame ss-high window
        tx1 = 8'hC3; slave_tx = 8'h3C; req1 = 1'b1;
        wait_gnt(20, ok);
        check("c_grant_seen", ok, 1);
        wait_ss_high(100, ok);
        check("c_ss_rise", ok, 1);
        hi = 0; sck_bad = 0;
        while (ss && hi < 50) begin
            hi++;
            if (sck) sck_bad++;
            @(negedge clk);
        end
        check("c_ss_high_cycles", hi, 8);
        check("c_sck_quiet", sck_bad, 0);
        check("c_second_gnt", gnt, 2'b10);
        req1 = 1'b0;
        wait_idle(200, ok);
        check("c_idle", ok, 1);

        // Mid-frame reset
        tx1 = 8'h55; slave_tx = 8'hAA; req1 = 1'b1;
        wait_gnt(20, ok);
        check("d_grant_seen", ok, 1);
        wait_rises(4, 100, ok);
        check("d_rises", ok, 1);
        rv_before = rv_count;
        rst = 1'b1;
        @(negedge clk);
        check("d_ss", ss, 1);
        check("d_sck", sck, 0);
        check("d_gnt", gnt, 0);
        check("d_busy", busy, 0);
        rst = 1'b0; req1 = 1'b0;
        repeat (100) @(negedge clk);
        check("d_no_rv", rv_count - rv_before, 0);
        tx1 = 8'hF0; slave_tx = 8'h5A; req1 = 1'b1;
        wait_gnt(20, ok);
        check("d_regrant", gnt, 2'b10);
        req1 = 1'b0;
        wait_rv(100, ok);
        check("d_rv_seen", ok, 1);
        check("d_rx_data", rx_data, 8'h5A);
        check("d_rx_id", rx_id, 1);
        check("d_sent", s_rx, 8'hF0);
        wait_idle(20, ok);

        // req0 dropped after two bits
        tx0 = 8'h96; slave_tx = 8'h69; req0 = 1'b1;
        wait_gnt(20, ok);
        check("e_grant_seen", ok, 1);
        rv_before = rv_count;
        wait_rises(2, 100, ok);
        check("e_rises", ok, 1);
        req0 = 1'b0;
        wait_idle(200, ok);
        check("e_idle", ok, 1);
        check("e_rv_once", rv_count - rv_before, 1);
        check("e_rx_data", rx_data, 8'h69);
        check("e_rx_id", rx_id, 0);
        check("e_sent", s_rx, 8'h96);
        repeat (10) @(negedge clk);
        check("e_no_grant", gnt, 0);
        check("e_not_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1);
    end
endmodule
